seg7_display_arbiter: RTL

Shares the 8-digit seven-segment display between up to `N_REQ` clock sub-blocks: time display, keyboard time entry, alarm set and stopwatch. It grants ownership by fixed priority with a minimum-hold guard, and blanks the display for one cycle between owners. It then scans the owner's six BCD digits onto the display with per-digit blink. It sits between the functional sub-blocks and the board pins, and replaces the per-block scan logic.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_display_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Segment codes are active-low: bit 7 is DP, bits 6..0 are g..a.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        OWN    = 2'd2
    } state_e;

    localparam int N_DIGITS = 6;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h98;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decode; non-BCD values show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Fixed-priority owner arbitration with minimum hold, one blank cycle between
// owners, and a free-running 8-position scan of the owner's six BCD digits.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int SCAN_DIV  = 50_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int HOLD_MIN  = 100_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*24-1:0]       data_i,
    input  logic [N_REQ*N_DIGITS-1:0] blink_i,
    output logic [N_REQ-1:0]          grant,
    output logic [7:0]                seg_en,
    output logic [7:0]                seg_out,
    output logic                      busy
);

    localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W  = $clog2(HOLD_MIN + 1);
    localparam int DIV_W   = $clog2(SCAN_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [2:0]           digit_q, digit_d;
    logic [BLINK_W-1:0]   bcnt_q, bcnt_d;
    logic                 blink_ph_q, blink_ph_d;
    logic [7:0]           seg_en_q, seg_en_d;
    logic [7:0]           seg_out_q, seg_out_d;

    logic [3:0]           nib [N_REQ][N_DIGITS];
    logic [N_DIGITS-1:0]  blink_arr [N_REQ];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign blink_arr[gi] = blink_i[N_DIGITS*gi +: N_DIGITS];
            for (gj = 0; gj < N_DIGITS; gj++) begin : g_dig
                assign nib[gi][gj] = data_i[24*gi + 4*gj +: 4];
            end
        end
    endgenerate

    logic               tick;
    logic               hold_done;
    logic               any_req;
    logic               higher_req;
    logic [OWNER_W-1:0] pick_idx;
    logic               digit_valid;
    logic [2:0]         digit_idx;
    logic [7:0]         dec_seg;

    assign tick        = (div_q == DIV_W'(SCAN_DIV - 1));
    assign hold_done   = (hold_q >= HOLD_W'(HOLD_MIN - 1));
    assign any_req     = |req;
    assign digit_valid = (digit_q < 3'(N_DIGITS));
    assign digit_idx   = digit_valid ? digit_q : 3'd0;

    seg7_decode u_decode (
        .bcd (nib[owner_q][digit_idx]),
        .seg (dec_seg)
    );

    always_comb begin
        pick_idx   = '0;
        higher_req = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) pick_idx = OWNER_W'(i);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if ((OWNER_W'(i) < owner_q) && req[i]) higher_req = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = SWITCH;
            end
            SWITCH: begin
                if (any_req) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    grant_d = N_REQ'(1) << pick_idx;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                hold_d = hold_done ? hold_q : hold_q + HOLD_W'(1);
                // Release wins over preemption when both happen together.
                if (!req[owner_q] || (hold_done && higher_req)) begin
                    state_d = SWITCH;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        digit_d    = tick ? digit_q + 3'd1 : digit_q;
        bcnt_d     = bcnt_q + BLINK_W'(1);
        blink_ph_d = blink_ph_q;
        if (bcnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            bcnt_d     = '0;
            blink_ph_d = ~blink_ph_q;
        end

        seg_en_d  = seg_en_q;
        seg_out_d = seg_out_q;
        // Blanking tracks the next state so it lands on the entry edge.
        if (state_d != OWN) begin
            seg_en_d  = SEG_BLANK;
            seg_out_d = SEG_BLANK;
        end else if (state_q == OWN && tick) begin
            if (digit_valid) begin
                seg_en_d  = ~(8'd1 << digit_q);
                seg_out_d = (blink_arr[owner_q][digit_idx] && !blink_ph_q) ? SEG_BLANK : dec_seg;
            end else begin
                seg_en_d  = SEG_BLANK;
                seg_out_d = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            hold_q     <= '0;
            div_q      <= '0;
            digit_q    <= 3'd0;
            bcnt_q     <= '0;
            blink_ph_q <= 1'b1;
            seg_en_q   <= SEG_BLANK;
            seg_out_q  <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            digit_q    <= digit_d;
            bcnt_q     <= bcnt_d;
            blink_ph_q <= blink_ph_d;
            seg_en_q   <= seg_en_d;
            seg_out_q  <= seg_out_d;
        end
    end

    assign grant   = grant_q;
    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;
    assign busy    = (state_q != IDLE);

endmodule
